// File: rtl/hex_lab_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hex_lab_pkg
// Description : Shared state encodings and default width for the hex adder
//               operand-entry front end.
// Revision    : 1.0 - initial release
// ============================================================================
package hex_lab_pkg;

  // Default operand width; must match the adder width.
  localparam int WIDTH_DEFAULT = 4;

  // Entry FSM encodings, also shown directly on the board LEDs.
  localparam logic [1:0] ST_LOAD_A  = 2'd0;
  localparam logic [1:0] ST_LOAD_B  = 2'd1;
  localparam logic [1:0] ST_COMPUTE = 2'd2;
  localparam logic [1:0] ST_SHOW    = 2'd3;

  typedef enum logic [1:0] {
    S_LOAD_A  = ST_LOAD_A,
    S_LOAD_B  = ST_LOAD_B,
    S_COMPUTE = ST_COMPUTE,
    S_SHOW    = ST_SHOW
  } state_e;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchroniser, level debouncer and rising-edge pulse
//               for a raw asynchronous push-button.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int         C_CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               sync1_q;
  logic               sync2_q;   // synchronised button (btn delayed 2 cycles)
  logic               level_q;   // accepted debounced level
  logic [C_CNT_W-1:0] cnt_q;     // consecutive cycles sync2_q has disagreed with level_q
  logic               press_q;

  // Synchronise, count disagreeing cycles, accept the new level after a full run, pulse on 0->1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == C_CNT_LAST) begin
        // This is the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
        level_q <= sync2_q;
        cnt_q   <= '0;
        press_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + C_CNT_W'(1);
      end
    end
  end

  assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/hex_adder.sv
`default_nettype none
// ============================================================================
// Module      : HexAdder
// Description : Gate-level ripple-carry adder driven by the operand loader.
// Revision    : 1.0 - initial release
// ============================================================================
module HexAdder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  logic [WIDTH:0] w_c;

  assign w_c[0] = Cin;

  // One full adder per bit, carry rippling upward.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic w_p;
      logic w_g;
      logic w_pc;
      xor u_p   (w_p, A[i], B[i]);
      xor u_s   (Sum[i], w_p, w_c[i]);
      and u_g   (w_g, A[i], B[i]);
      and u_pc  (w_pc, w_p, w_c[i]);
      or  u_c   (w_c[i+1], w_g, w_pc);
    end
  endgenerate

  assign Cout = w_c[WIDTH];

endmodule
`default_nettype wire

// File: rtl/hex_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : hex_operand_loader
// Description : Captures operands A, B and carry-in from switches on
//               debounced presses, drives them to the external adder and
//               registers the adder result for display.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_operand_loader
  import hex_lab_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WIDTH           = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             cin_sw,
  input  logic             btn,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_cin,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             cout_in,
  output logic [WIDTH:0]   result,
  output logic             result_valid,
  output logic [1:0]       state_led
);

  logic w_press;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .press (w_press)
  );

  state_e           state_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic             op_cin_q;
  logic [WIDTH:0]   result_q;
  logic             valid_q;

  // Entry FSM: A on first press, B/cin on second, one settle cycle, then hold the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_LOAD_A;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_cin_q <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD_A: begin
          if (w_press) begin
            op_a_q  <= sw;
            state_q <= S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (w_press) begin
            op_b_q   <= sw;
            op_cin_q <= cin_sw;
            state_q  <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          // Operands have been stable on the adder for a full cycle here.
          result_q <= {cout_in, sum_in};
          valid_q  <= 1'b1;
          state_q  <= S_SHOW;
        end
        S_SHOW: begin
          if (w_press) begin
            valid_q <= 1'b0;
            state_q <= S_LOAD_A;
          end
        end
        default: state_q <= S_LOAD_A;
      endcase
    end
  end

  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign op_cin       = op_cin_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign state_led    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_operand_loader
// Description : Directed self-checking bench for hex_operand_loader wired to
//               the gate-level HexAdder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_operand_loader;

  localparam int DC = 4;
  localparam int W  = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw = '0;
  logic         cin_sw = 1'b0;
  logic         btn = 1'b0;
  logic [W-1:0] op_a, op_b, sum_w;
  logic         op_cin, cout_w;
  logic [W:0]   result;
  logic         result_valid;
  logic [1:0]   state_led;

  int total = 0;
  int bad   = 0;
  int press_cnt = 0;

  always #5 clk = ~clk;

  hex_operand_loader #(.DEBOUNCE_CYCLES(DC), .WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .sw           (sw),
    .cin_sw       (cin_sw),
    .btn          (btn),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_cin       (op_cin),
    .sum_in       (sum_w),
    .cout_in      (cout_w),
    .result       (result),
    .result_valid (result_valid),
    .state_led    (state_led)
  );

  HexAdder #(.WIDTH(W)) u_adder (
    .A    (op_a),
    .B    (op_b),
    .Cin  (op_cin),
    .Sum  (sum_w),
    .Cout (cout_w)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count press pulses; a press must never land in COMPUTE.
  always @(negedge clk) begin
    if (dut.w_press) press_cnt++;
    if (state_led == 2'd2) check("press_in_compute", {7'd0, dut.w_press}, 8'd0);
  end

  // Raise btn and return at the negedge where the press pulse is visible.
  task automatic press_start();
    bit seen;
    seen = 1'b0;
    btn = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (dut.w_press) seen = 1'b1;
    end
    if (!seen) check("press_timeout", 8'd0, 8'd1);
  endtask

  task automatic release_btn();
    btn = 1'b0;
    repeat (2 * DC + 6) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    btn = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  int p0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_state", {6'd0, state_led}, 8'd0);
    check("rst_op_a", {4'd0, op_a}, 8'd0);
    check("rst_op_b", {4'd0, op_b}, 8'd0);
    check("rst_cin", {7'd0, op_cin}, 8'd0);
    check("rst_result", {3'd0, result}, 8'd0);
    check("rst_valid", {7'd0, result_valid}, 8'd0);

    // Short pulse: btn high DC-1 cycles must not be accepted
    sw = 4'hA;
    p0 = press_cnt;
    btn = 1'b1;
    repeat (DC - 1) @(negedge clk);
    btn = 1'b0;
    repeat (12) @(negedge clk);
    check("short_no_press", 8'(press_cnt - p0), 8'd0);
    check("short_state", {6'd0, state_led}, 8'd0);
    check("short_op_a", {4'd0, op_a}, 8'd0);

    // 9 + 8 + 0 = 0x11 with latency check
    sw = 4'h9;
    press_start();
    release_btn();
    check("t1_state_b", {6'd0, state_led}, 8'd1);
    sw = 4'h8; cin_sw = 1'b0;
    press_start();
    @(negedge clk);
    check("t1_compute", {6'd0, state_led}, 8'd2);
    check("t1_valid_early", {7'd0, result_valid}, 8'd0);
    @(negedge clk);
    check("t1_op_a", {4'd0, op_a}, 8'h09);
    check("t1_op_b", {4'd0, op_b}, 8'h08);
    check("t1_result", {3'd0, result}, 8'h11);
    check("t1_valid", {7'd0, result_valid}, 8'd1);
    check("t1_show", {6'd0, state_led}, 8'd3);
    release_btn();

    // Leave SHOW, then F + F + 1 = 0x1F
    press_start();
    @(negedge clk);
    check("t2_back_a", {6'd0, state_led}, 8'd0);
    check("t2_hold_res", {3'd0, result}, 8'h11);
    release_btn();
    sw = 4'hF;
    press_start();
    release_btn();
    cin_sw = 1'b1;
    press_start();
    repeat (2) @(negedge clk);
    check("t2_result", {3'd0, result}, 8'h1F);
    check("t2_valid", {7'd0, result_valid}, 8'd1);
    release_btn();
    press_start();
    @(negedge clk);
    check("t2_valid_clr", {7'd0, result_valid}, 8'd0);
    check("t2_state", {6'd0, state_led}, 8'd0);
    check("t2_res_kept", {3'd0, result}, 8'h1F);
    release_btn();

    // Held button: exactly one press, stop in LOAD_B
    sw = 4'h1;
    p0 = press_cnt;
    btn = 1'b1;
    repeat (50) @(negedge clk);
    check("hold_one_press", 8'(press_cnt - p0), 8'd1);
    check("hold_state", {6'd0, state_led}, 8'd1);
    check("hold_op_a", {4'd0, op_a}, 8'h01);
    release_btn();
    check("hold_rel_state", {6'd0, state_led}, 8'd1);

    // Reset mid-entry, then fresh entry 2 + 5 + 1 = 0x08
    do_reset();
    sw = 4'h3;
    press_start();
    release_btn();
    check("mid_state_b", {6'd0, state_led}, 8'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_state", {6'd0, state_led}, 8'd0);
    check("mid_rst_op_a", {4'd0, op_a}, 8'd0);
    check("mid_rst_valid", {7'd0, result_valid}, 8'd0);
    sw = 4'h2;
    press_start();
    release_btn();
    sw = 4'h5; cin_sw = 1'b1;
    press_start();
    repeat (2) @(negedge clk);
    check("t5_result", {3'd0, result}, 8'h08);
    release_btn();

    // Switch sweep in LOAD_B without pressing
    do_reset();
    sw = 4'h7; cin_sw = 1'b0;
    press_start();
    release_btn();
    for (int v = 0; v < 16; v++) begin
      sw = 4'(v);
      @(negedge clk);
      check("sweep_op_a", {4'd0, op_a}, 8'h07);
      check("sweep_op_b", {4'd0, op_b}, 8'h00);
    end
    sw = 4'hC;
    press_start();
    @(negedge clk);
    check("sweep_op_b_cap", {4'd0, op_b}, 8'h0C);
    @(negedge clk);
    check("sweep_result", {3'd0, result}, 8'h13);
    release_btn();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
